// File: rtl/legv8_dmem_ctrl_if.sv
// legv8_dmem_ctrl_if: request/response handshake bundle between the memory stage and the data RAM controller
interface legv8_dmem_ctrl_if #(parameter int DATA_W = 64);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [63:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              resp_write;
    modport master(
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_write
    );
    modport slave(
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_write
    );
endinterface

// File: rtl/legv8_dmem_ctrl.sv
// legv8_dmem_ctrl: LEGv8 data RAM initiator; one load/store in flight with alignment and range checking
module legv8_dmem_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    legv8_dmem_ctrl_if.slave     bus,
    output logic [ADDR_BITS-1:0] ram_address,
    output logic [DATA_W-1:0]    ram_in,
    output logic                 ram_writeEn,
    input  logic [DATA_W-1:0]    ram_out
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic                 fault;
    assign fault = (bus.req_addr[2:0] != 3'd0) || (bus.req_addr[63:ADDR_BITS+3] != '0);
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr[ADDR_BITS+2:3];
                wdata_d = bus.req_wdata;
                write_d = bus.req_write;
                err_d   = fault;
                rdata_d = '0;
                state_d = fault ? RESP : ACCESS;
            end
            ACCESS: begin
                rdata_d = write_q ? '0 : ram_out;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end
    // write enable decodes straight off the state register so async reset kills it at once
    assign ram_writeEn    = (state_q == ACCESS) && write_q;
    assign ram_address    = addr_q;
    assign ram_in         = wdata_q;
    assign bus.req_ready  = state_q == IDLE;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_write = write_q;
endmodule

// File: tb/tb_legv8_dmem_ctrl.sv
// tb_legv8_dmem_ctrl: scoreboard bench for legv8_dmem_ctrl with a combinational-read RAM model
module tb_legv8_dmem_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  ram_address;
    logic [63:0] ram_in;
    logic        ram_writeEn;
    logic [63:0] ram_out;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    legv8_dmem_ctrl_if #(.DATA_W(64)) bus();
    legv8_dmem_ctrl #(.ADDR_BITS(8), .DATA_W(64)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .ram_address(ram_address), .ram_in(ram_in),
        .ram_writeEn(ram_writeEn), .ram_out(ram_out)
    );
    always #5 clock = ~clock;
    function automatic logic [63:0] pat(input logic [7:0] i);
        return 64'h0123_4567_0000_0000 | ({56'd0, i} * 64'h0101);
    endfunction
    logic [63:0] ram [256];
    logic        ram_vld [256] = '{default: 1'b0};
    assign ram_out = ram_vld[ram_address] ? ram[ram_address] : pat(ram_address);
    always @(posedge clock) if (ram_writeEn) begin
        ram[ram_address]     <= ram_in;
        ram_vld[ram_address] <= 1'b1;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        logic        write;
        logic [7:0]  idx;
        logic [63:0] wdata;
        int          lat;
        int          we;
        int          acc;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic [63:0] ref_mem [256];
    logic        ref_vld [256] = '{default: 1'b0};
    int          we_cnt = 0;
    bit          seen_valid = 0;
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            sb.delete();
            we_cnt = 0;
            seen_valid = 0;
        end else begin
            if (ram_writeEn) begin
                we_cnt++;
                if (sb.size() > 0) begin
                    check("ram_address", {56'd0, ram_address}, {56'd0, sb[0].idx});
                    check("ram_in", ram_in, sb[0].wdata);
                end
            end
            if (bus.resp_valid) begin
                if (sb.size() == 0) check("resp_unexpected", 1, 0);
                else begin
                    check("resp_rdata", bus.resp_rdata, sb[0].rdata);
                    check("resp_err", {63'd0, bus.resp_err}, {63'd0, sb[0].err});
                    check("resp_write", {63'd0, bus.resp_write}, {63'd0, sb[0].write});
                    check("req_ready_in_resp", {63'd0, bus.req_ready}, 0);
                    if (!seen_valid) check("latency", cyc - sb[0].acc, sb[0].lat);
                    seen_valid = 1;
                    if (bus.resp_ready) begin
                        check("we_cycles", we_cnt, sb[0].we);
                        if (sb[0].write && !sb[0].err) begin
                            ref_mem[sb[0].idx] = sb[0].wdata;
                            ref_vld[sb[0].idx] = 1'b1;
                        end
                        void'(sb.pop_front());
                        we_cnt = 0;
                        seen_valid = 0;
                    end
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                e.idx   = bus.req_addr[10:3];
                e.write = bus.req_write;
                e.wdata = bus.req_wdata;
                e.err   = (bus.req_addr[2:0] != 0) || (bus.req_addr[63:11] != 0);
                e.rdata = (e.err || e.write) ? 64'd0 : (ref_vld[e.idx] ? ref_mem[e.idx] : pat(e.idx));
                e.lat   = e.err ? 1 : 2;
                e.we    = (e.write && !e.err) ? 1 : 0;
                e.acc   = cyc;
                sb.push_back(e);
            end
        end
    end
    task automatic send(input logic wr, input logic [63:0] addr, input logic [63:0] wd, output time t);
        bit ok = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        t = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.req_ready) begin
                ok = 1;
                t = $time;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask
    task automatic drain();
        bit ok = 0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
        @(posedge clock);
        #1;
    endtask
    time t0, t1, t2;
    bit  hit;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready", {63'd0, bus.req_ready}, 1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 0);
        check("rst_resp_rdata", bus.resp_rdata, 0);
        check("rst_resp_err", {63'd0, bus.resp_err}, 0);
        check("rst_resp_write", {63'd0, bus.resp_write}, 0);
        check("rst_ram_address", {56'd0, ram_address}, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_ram_writeEn", {63'd0, ram_writeEn}, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        send(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, t0); drain();
        send(1'b0, 64'h10, 64'd0, t0); drain();
        send(1'b0, 64'h0C, 64'd0, t0); drain();
        send(1'b1, 64'h800, 64'h1234, t0); drain();
        check("oor_ram0_untouched", ram_vld[0] ? ram[0] : pat(8'd0), pat(8'd0));
        send(1'b0, 64'h0, 64'd0, t0); drain();
        send(1'b1, 64'h7F8, 64'd5, t0); drain();
        send(1'b0, 64'h7F8, 64'd0, t0); drain();
        send(1'b0, 64'h8000_0000_0000_0010, 64'd0, t0); drain();
        // backpressure: hold the response for four cycles
        bus.resp_ready = 1'b0;
        send(1'b0, 64'h10, 64'd0, t0);
        bus.req_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                hit = 1;
                break;
            end
        end
        check("bp_resp_seen", {63'd0, hit}, 1);
        repeat (4) begin
            @(negedge clock);
            check("bp_resp_valid", {63'd0, bus.resp_valid}, 1);
            check("bp_req_ready", {63'd0, bus.req_ready}, 0);
        end
        @(posedge clock);
        #1 bus.resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_idle_req_ready", {63'd0, bus.req_ready}, 1);
        check("bp_idle_resp_valid", {63'd0, bus.resp_valid}, 0);
        @(posedge clock);
        #1;
        // async reset while the store sits in ACCESS
        send(1'b1, 64'h18, 64'hBAD0_BAD0_BAD0_BAD0, t0);
        bus.req_valid = 1'b0;
        check("rst_mid_we_before", {63'd0, ram_writeEn}, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we", {63'd0, ram_writeEn}, 0);
        check("rst_mid_resp_valid", {63'd0, bus.resp_valid}, 0);
        check("rst_mid_req_ready", {63'd0, bus.req_ready}, 1);
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        check("rst_mid_ram3", ram_vld[3] ? ram[3] : pat(8'd3), pat(8'd3));
        send(1'b0, 64'h18, 64'd0, t0); drain();
        // back-to-back loads with req_valid held high
        send(1'b0, 64'h10, 64'd0, t0);
        send(1'b0, 64'h7F8, 64'd0, t1);
        send(1'b0, 64'h18, 64'd0, t2);
        drain();
        check("b2b_spacing_1", t1 - t0, 30);
        check("b2b_spacing_2", t2 - t1, 30);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/legv8_dmem_ctrl.md
Name: legv8_dmem_ctrl

Overview:
- Initiator side of the LEGv8 data RAM port. Accepts load/store requests from the pipeline's memory stage over a valid/ready handshake.
- Converts 64-bit byte addresses to RAM word indices and checks alignment and range.
- Drives the RAM address, write-data and write-enable lines, captures read data, and returns a response over a second valid/ready handshake.
- One request is in flight at a time. The RAM read path is combinational; its writes occur on the clock edge.

Parameters:
- ADDR_BITS, 8, width of the RAM word index; RAM depth is 2^ADDR_BITS words.
- DATA_W, 64, data word width; word size is 8 bytes, so byte offset is addr[2:0].

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_wdata  input  DATA_W  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  DATA_W  load data; 0 for stores and faults.
- resp_err  output  1  1 = misaligned or out-of-range access.
- resp_write  output  1  echo of the request's req_write.
- ram_address  output  ADDR_BITS  word index to RAM.
- ram_in  output  DATA_W  write data to RAM.
- ram_writeEn  output  1  RAM write enable.
- ram_out  input  DATA_W  RAM combinational read data.

Behaviour:
- Reset value of every output is 0, except req_ready, which is 1 (IDLE). Internal registers for state, latched address, data, write flag, read data and error also reset to 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - A handshake occurs when req_valid & req_ready at a posedge. On handshake, latch req_write, req_wdata and word index req_addr[ADDR_BITS+2:3].
  - Fault = (req_addr[2:0] != 0) or (req_addr[63:ADDR_BITS+3] != 0).
  - Fault: set err = 1, rdata = 0, next state RESP. The RAM is never touched.
  - No fault: next state ACCESS.
- ACCESS (exactly one cycle):
  - req_ready = 0.
  - ram_writeEn = latched write.
  - ram_address = latched index; ram_in = latched wdata.
  - At the closing edge: loads capture ram_out into rdata; stores set rdata = 0. err = 0. Next state RESP.
- RESP:
  - resp_valid = 1; resp_rdata, resp_err and resp_write are held stable.
  - When resp_ready is high at a posedge, go to IDLE.
  - req_ready = 0 throughout RESP; no new request is accepted in the same cycle as the response handshake.
- ram_writeEn is high only in ACCESS with a store; it is combinationally decoded from the state register, so it drops with async reset.
- ram_address and ram_in are registered and hold their last latched values outside ACCESS. The RAM is read-only outside ACCESS.
- Latency from request handshake to resp_valid:
  - valid access: 2 cycles.
  - fault: 1 cycle.
  - Minimum request-to-request spacing: 3 cycles.
- Read-after-write: a store commits to the RAM at the end of its ACCESS cycle, so a following load to the same index returns the new data.
- Backpressure: resp_valid stays high and all resp_* outputs stay constant while resp_ready is low. req_* inputs are ignored outside IDLE.
- Reset asserted mid-operation: state returns to IDLE immediately and any pending response is discarded. A store interrupted in ACCESS before its closing edge is not written.
- Boundary addresses:
  - 0x7F8 is the last valid address (index 255).
  - 0x800 faults.
  - Any set bit in [63:11] faults.

Test Plan:
- Store then load: store 0x10, data 0xDEADBEEF_CAFEF00D -> ram_writeEn high for exactly 1 cycle with ram_address = 2; resp err = 0, rdata = 0. Load 0x10 -> resp_rdata = 0xDEADBEEF_CAFEF00D, resp_valid 2 cycles after acceptance.
- Misaligned address: load 0x0C -> resp_valid 1 cycle after acceptance, resp_err = 1, resp_rdata = 0, ram_writeEn never asserted.
- Out of range: store 0x800 -> resp_err = 1 and RAM contents unchanged. Store 0x7F8, data 5 -> ram_address = 255, err = 0; a following load returns 5.
- Backpressure: hold resp_ready = 0 for 4 cycles after resp_valid -> resp_* stable and req_ready = 0 throughout. Release -> IDLE, req_ready = 1 on the next cycle.
- Async reset in ACCESS: assert reset mid-cycle during a store to 0x18 -> ram_writeEn drops immediately, resp_valid = 0, req_ready = 1. A subsequent load of 0x18 returns the previous contents.
- Back-to-back: req_valid held high with 3 queued loads, resp_ready = 1 -> accepts are spaced exactly 3 cycles apart and responses return in order with correct data.
